// File: rtl/xor_stream_decipher.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// xor_stream_decipher
//
// Receive-side half of the XOR stream cipher. A 16-bit seed arrives as two
// key bytes (high byte first). The seed initialises a Galois LFSR that
// regenerates the encryptor's keystream. Each accepted ciphertext byte is
// XORed with the low byte of the LFSR. The LFSR then advances by
// STEPS_PER_BYTE shifts. Plaintext leaves through a one-entry registered
// valid/ready buffer.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   key_valid  key byte offered       key_byte  seed byte (hi, then lo)
//   key_ready  key byte can be taken
//   resync     pulse: restart keystream from the stored seed (RUN only)
//   ct_valid   ciphertext offered     ct_data   ciphertext byte
//   ct_ready   ciphertext can be taken
//   pt_valid   plaintext available    pt_data   plaintext byte
//   pt_ready   consumer takes plaintext
//   key_zero   last loaded key was all-zero, DEFAULT_SEED in use
// ---------------------------------------------------------------------------
module xor_stream_decipher #(
    parameter logic [15:0] LFSR_TAPS      = 16'hB400,
    parameter logic [15:0] DEFAULT_SEED   = 16'hACE1,
    parameter int unsigned STEPS_PER_BYTE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [7:0] key_byte,
    output logic       key_ready,
    input  logic       resync,
    input  logic       ct_valid,
    input  logic [7:0] ct_data,
    output logic       ct_ready,
    output logic       pt_valid,
    output logic [7:0] pt_data,
    input  logic       pt_ready,
    output logic       key_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // waiting for seed high byte
        ST_LOAD = 2'd1,   // waiting for seed low byte
        ST_RUN  = 2'd2    // deciphering
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] seed_reg, seed_next;
    logic [15:0] lfsr_reg, lfsr_next;
    logic        pt_valid_reg, pt_valid_next;
    logic [7:0]  pt_data_reg, pt_data_next;
    logic        key_zero_reg, key_zero_next;

    // Seed as it will look once the low key byte on the bus is taken.
    logic [15:0] loaded_seed;
    assign loaded_seed = {seed_reg[15:8], key_byte};

    // Keystream advance: an unrolled chain of STEPS_PER_BYTE Galois shifts,
    // so the whole per-byte advance happens in the same cycle as the accept.
    logic [15:0] ks_chain [0:STEPS_PER_BYTE];
    assign ks_chain[0] = lfsr_reg;

    generate
        for (genvar gi = 0; gi < STEPS_PER_BYTE; gi++) begin : g_step
            assign ks_chain[gi+1] = ks_chain[gi][0]
                                  ? ((ks_chain[gi] >> 1) ^ LFSR_TAPS)
                                  :  (ks_chain[gi] >> 1);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            seed_reg     <= 16'h0000;
            lfsr_reg     <= 16'h0000;
            pt_valid_reg <= 1'b0;
            pt_data_reg  <= 8'h00;
            key_zero_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            seed_reg     <= seed_next;
            lfsr_reg     <= lfsr_next;
            pt_valid_reg <= pt_valid_next;
            pt_data_reg  <= pt_data_next;
            key_zero_reg <= key_zero_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and handshake logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        seed_next     = seed_reg;
        lfsr_next     = lfsr_reg;
        pt_valid_next = pt_valid_reg;
        pt_data_next  = pt_data_reg;
        key_zero_next = key_zero_reg;
        key_ready     = 1'b1;
        ct_ready      = 1'b0;

        // Output buffer drains whenever the consumer takes the byte; a new
        // byte loaded below on the same edge overrides this.
        if (pt_valid_reg && pt_ready) begin
            pt_valid_next = 1'b0;
        end

        case (state_reg)
            ST_IDLE: begin
                if (key_valid) begin
                    seed_next[15:8] = key_byte;
                    state_next      = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (key_valid) begin
                    seed_next[7:0] = key_byte;
                    // An all-zero seed would lock the LFSR at zero.
                    lfsr_next      = (loaded_seed == 16'h0000) ? DEFAULT_SEED : loaded_seed;
                    key_zero_next  = (loaded_seed == 16'h0000);
                    state_next     = ST_RUN;
                end
            end

            ST_RUN: begin
                // Rekey only with an empty buffer, so no plaintext from the
                // old key stream can be left behind.
                key_ready = !pt_valid_reg;
                // Deasserted while a higher-priority action is requested,
                // which keeps at most one action per cycle.
                ct_ready  = (!pt_valid_reg || pt_ready) && !key_valid && !resync;

                if (key_valid && key_ready) begin
                    // lfsr keeps running state until the low byte completes.
                    seed_next[15:8] = key_byte;
                    state_next      = ST_LOAD;
                end else if (resync) begin
                    lfsr_next = key_zero_reg ? DEFAULT_SEED : seed_reg;
                end else if (ct_valid && ct_ready) begin
                    pt_data_next  = ct_data ^ lfsr_reg[7:0];
                    pt_valid_next = 1'b1;
                    lfsr_next     = ks_chain[STEPS_PER_BYTE];
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign pt_valid = pt_valid_reg;
    assign pt_data  = pt_data_reg;
    assign key_zero = key_zero_reg;

endmodule

// File: tb/tb_xor_stream_decipher.sv
`timescale 1ns/1ps
module tb_xor_stream_decipher;

    localparam logic [15:0] TAPS  = 16'hB400;
    localparam logic [15:0] DSEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [7:0] key_byte;
    logic       key_ready;
    logic       resync;
    logic       ct_valid;
    logic [7:0] ct_data;
    logic       ct_ready;
    logic       pt_valid;
    logic [7:0] pt_data;
    logic       pt_ready;
    logic       key_zero;

    always #5 clk = ~clk;

    xor_stream_decipher dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_byte  (key_byte),
        .key_ready (key_ready),
        .resync    (resync),
        .ct_valid  (ct_valid),
        .ct_data   (ct_data),
        .ct_ready  (ct_ready),
        .pt_valid  (pt_valid),
        .pt_data   (pt_data),
        .pt_ready  (pt_ready),
        .key_zero  (key_zero)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: expected plaintext queue plus a reference keystream.
    logic [7:0]  exp_q[$];
    int          mode = 0;         // 0 = no key, 1 = half key, 2 = running
    logic        model_kz = 1'b0;
    logic [15:0] enc_seed = 16'h0000;
    logic [15:0] enc_lfsr = 16'h0000;
    logic [7:0]  key_hi = 8'h00;
    bit          bp_random = 1'b0;
    bit          ready_fix = 1'b1;

    function automatic logic [15:0] advance(input logic [15:0] s, input int n);
        logic [15:0] v;
        v = s;
        for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Next keystream byte of the reference encryptor.
    function automatic logic [7:0] ks_take();
        logic [7:0] k;
        k = enc_lfsr[7:0];
        enc_lfsr = advance(enc_lfsr, 8);
        return k;
    endfunction

    // pt_ready driver: fixed level or random backpressure.
    initial begin
        pt_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pt_ready = bp_random ? 1'($urandom_range(0, 1)) : ready_fix;
        end
    end

    // Compare process: handshake rules, hold stability, and plaintext order.
    logic       hold_prev = 1'b0;
    logic [7:0] hold_data = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (mode == 2) begin
                chk("key_ready_run", key_ready, !pt_valid);
                chk("ct_ready_run", ct_ready, (!pt_valid || pt_ready) && !key_valid && !resync);
            end else begin
                chk("key_ready_loading", key_ready, 1);
                chk("ct_ready_loading", ct_ready, 0);
            end
            chk("key_zero", key_zero, model_kz);
            if (hold_prev) begin
                chk("hold_valid", pt_valid, 1);
                chk("hold_data", pt_data, hold_data);
            end
            if (pt_valid && pt_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pt_extra: got 0x%02h, required no byte", pt_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk("pt_data", pt_data, e);
                    $display("pt byte 0x%02h (expected 0x%02h) at %0t", pt_data, e, $time);
                end
            end
            hold_prev = pt_valid && !pt_ready;
            hold_data = pt_data;
        end
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_key(input logic [7:0] b);
        int n;
        n = 0;
        key_valid = 1'b1;
        key_byte  = b;
        @(negedge clk);
        while (!key_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!key_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL key_timeout: got key_ready=0, required 1 within 100 cycles");
            key_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        if (mode == 1) begin
            enc_seed = {key_hi, b};
            model_kz = (enc_seed == 16'h0000);
            enc_lfsr = model_kz ? DSEED : enc_seed;
            mode = 2;
        end else begin
            key_hi = b;
            mode = 1;
        end
    endtask

    task automatic send_ct(input logic [7:0] c);
        int n;
        n = 0;
        ct_valid = 1'b1;
        ct_data  = c;
        @(negedge clk);
        while (!ct_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ct_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ct_timeout: got ct_ready=0, required 1 within 100 cycles");
            ct_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        ct_valid = 1'b0;
    endtask

    // Send a given ciphertext; the model derives the expected plaintext.
    task automatic send_ct_exp(input logic [7:0] c);
        exp_q.push_back(c ^ ks_take());
        send_ct(c);
    endtask

    // Encrypt a plaintext with the reference encryptor and send it.
    task automatic send_plain(input logic [7:0] p);
        logic [7:0] c;
        c = p ^ ks_take();
        exp_q.push_back(p);
        send_ct(c);
    endtask

    task automatic do_resync();
        resync = 1'b1;
        sync();
        resync = 1'b0;
        enc_lfsr = model_kz ? DSEED : enc_seed;
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #3;
        rst = 1'b1;
        mode = 0;
        model_kz = 1'b0;
        exp_q.delete();
        key_valid = 1'b0;
        ct_valid = 1'b0;
        resync = 1'b0;
        #1;
        chk("rst_pt_valid", pt_valid, 0);
        chk("rst_key_ready", key_ready, 1);
        chk("rst_ct_ready", ct_ready, 0);
        chk("rst_key_zero", key_zero, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] tmp;
        logic [15:0] rkey;

        rst = 1'b1;
        key_valid = 1'b0;
        key_byte = 8'h00;
        resync = 1'b0;
        ct_valid = 1'b0;
        ct_data = 8'h00;

        // Pin the reference model against hand-computed values.
        tmp = advance(16'h0001, 8);
        chk("model_step8", tmp, 16'h0168);
        tmp = DSEED;
        chk("model_default_lo", tmp[7:0], 8'hE1);

        #12;
        chk("reset_pt_valid", pt_valid, 0);
        chk("reset_pt_data", pt_data, 8'h00);
        chk("reset_key_zero", key_zero, 0);
        chk("reset_key_ready", key_ready, 1);
        chk("reset_ct_ready", ct_ready, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        sync();

        // Key 0x0001, two ciphertext bytes, 1-cycle latency.
        send_key(8'h00);
        send_key(8'h01);
        send_ct_exp(8'h41);
        @(negedge clk);
        chk("t1_valid", pt_valid, 1);
        chk("t1_pt0", pt_data, 8'h40);
        sync();
        send_ct_exp(8'h68);
        @(negedge clk);
        chk("t1_pt1", pt_data, 8'h00);
        sync();

        // All-zero key selects the default seed.
        send_key(8'h00);
        send_key(8'h00);
        @(negedge clk);
        chk("t2_key_zero", key_zero, 1);
        sync();
        send_ct_exp(8'h00);
        @(negedge clk);
        chk("t2_pt", pt_data, 8'hE1);
        sync();

        // Backpressure: buffer holds, ct stalls, then streaming resumes.
        send_key(8'h00);
        send_key(8'h01);
        ready_fix = 1'b0;
        send_ct_exp(8'h41);
        exp_q.push_back(8'h68 ^ ks_take());
        ct_valid = 1'b1;
        ct_data = 8'h68;
        repeat (4) begin
            @(negedge clk);
            chk("t3_ct_stall", ct_ready, 0);
            chk("t3_valid_hold", pt_valid, 1);
            chk("t3_data_hold", pt_data, 8'h40);
        end
        ready_fix = 1'b1;
        send_ct(8'h68);
        @(negedge clk);
        chk("t3_resume", pt_data, 8'h00);
        sync();

        // Resync restarts the keystream.
        send_key(8'h00);
        send_key(8'h01);
        send_ct_exp(8'h41);
        @(negedge clk);
        chk("t4_pt0", pt_data, 8'h40);
        sync();
        do_resync();
        send_ct_exp(8'h41);
        @(negedge clk);
        chk("t4_pt1", pt_data, 8'h40);
        sync();

        // Rekey blocked while the output buffer is full.
        ready_fix = 1'b0;
        sync();
        send_ct_exp(8'h41);
        key_valid = 1'b1;
        key_byte = 8'h12;
        repeat (3) begin
            @(negedge clk);
            chk("t4_rekey_blocked", key_ready, 0);
        end
        ready_fix = 1'b1;
        send_key(8'h12);
        send_key(8'h34);

        // Reset between key bytes, then after one buffered ct byte.
        send_key(8'h55);
        pulse_rst();
        sync();
        send_key(8'h12);
        send_key(8'h34);
        ready_fix = 1'b0;
        send_ct_exp(8'h77);
        pulse_rst();
        sync();
        ct_valid = 1'b1;
        ct_data = 8'h77;
        repeat (3) begin
            @(negedge clk);
            chk("t5_no_ct_after_rst", ct_ready, 0);
            chk("t5_pt_lost", pt_valid, 0);
        end
        sync();
        ct_valid = 1'b0;
        ready_fix = 1'b1;
        send_key(8'h12);
        send_key(8'h34);
        send_ct_exp(8'h77);
        @(negedge clk);
        chk("t5_reload_pt", pt_data, 8'h43);
        sync();

        // Random 256-byte stream with random backpressure and gaps.
        rkey = 16'($urandom());
        bp_random = 1'b1;
        send_key(rkey[15:8]);
        send_key(rkey[7:0]);
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 3) == 0) sync();
            if (i == 128) do_resync();
            send_plain(8'($urandom()));
        end
        bp_random = 1'b0;
        ready_fix = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        chk("random_drained", exp_q.size(), 0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
